vic_apb_nested: RTL and testbench

- Parametrised APB vectored interrupt controller; successor to the fixed 32-source VIC top.
- NUM_SRC sources, each with:
  - programmable priority;
  - level or rising-edge sensing;
  - own vector address.
- Nested IRQ handling through a hardware priority stack; FIQ routing per source.
- Sits on the APB peripheral bus and drives the CPU active-low FIQ/IRQ lines.

---
 rtl/vic_apb_nested_if.sv | 22 ++
 rtl/vic_apb_nested.sv | 185 ++++++++++++++++++
 tb/tb_vic_apb_nested.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vic_apb_nested_if.sv
// APB slave bus bundle for the vectored interrupt controller.
interface vic_apb_nested_if #(
    parameter int unsigned AW = 12
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/vic_apb_nested.sv
// Parametrised APB vectored interrupt controller with a nested-priority stack.
module vic_apb_nested #(
    parameter int unsigned NUM_SRC   = 32,
    parameter int unsigned PRIO_BITS = 4,
    parameter int unsigned AW        = 12
) (
    input  logic               pclk,
    input  logic               rst,
    vic_apb_nested_if.slave    apb,
    input  logic [NUM_SRC-1:0] vic_intsource,
    output logic               nvicfiq,
    output logic               nvicirq
);
    localparam int unsigned NLEV = 1 << PRIO_BITS;
    localparam int unsigned CPW  = PRIO_BITS + 1;
    localparam int unsigned IW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned PW   = AW - 8;

    localparam logic [5:0] A_IRQSTAT = 6'h00, A_FIQSTAT = 6'h01, A_RAW     = 6'h02;
    localparam logic [5:0] A_INTSEL  = 6'h03, A_INTEN   = 6'h04, A_INTENCL = 6'h05;
    localparam logic [5:0] A_SOFT    = 6'h06, A_SOFTCL  = 6'h07, A_EDGESEL = 6'h08;
    localparam logic [5:0] A_EDGECL  = 6'h09, A_PMASK   = 6'h0A, A_VECT    = 6'h0C;
    localparam logic [5:0] A_DEFV    = 6'h0D, A_CURPRIO = 6'h0E;

    logic [NUM_SRC-1:0]   src_q, edge_lat, intselect, intenable, softint, edgesel;
    logic [NUM_SRC-1:0]   hw, raw, pend, fiq_status, irq_status, wdat, ack_clr, edge_clr;
    logic [NLEV-1:0]      prio_mask;
    logic [31:0]          def_vect, rdata;
    logic [31:0]          vect_addr [NUM_SRC];
    logic [PRIO_BITS-1:0] vect_prio [NUM_SRC];
    logic [PRIO_BITS-1:0] stk [NLEV];
    logic [CPW-1:0]       sp, sp_m1, cur_prio, best;
    logic                 acc, wr, rd, is_ctrl, is_vect, is_prio, in_range, ack, eoi;
    logic [5:0]           word;
    logic [PW-1:0]        page;
    logic [IW-1:0]        idx, win_idx;
    logic [PRIO_BITS-1:0] win_prio;
    logic                 win_valid;
    logic                 unused_bits;

    assign acc      = apb.psel & apb.penable;
    assign wr       = acc & apb.pwrite;
    assign rd       = acc & ~apb.pwrite;
    assign word     = apb.paddr[7:2];
    assign page     = apb.paddr[AW-1:8];
    assign idx      = word[IW-1:0];
    assign is_ctrl  = (page == PW'(0));
    assign is_vect  = (page == PW'(1));
    assign is_prio  = (page == PW'(2));
    assign in_range = ({26'd0, word} < 32'(NUM_SRC));
    assign ack      = rd & is_ctrl & (word == A_VECT);
    assign eoi      = wr & is_ctrl & (word == A_VECT);
    assign wdat     = apb.pwdata[NUM_SRC-1:0];
    assign unused_bits = &{1'b0, apb.paddr[1:0]};

    assign hw         = (edgesel & edge_lat) | (~edgesel & src_q);
    assign raw        = hw | softint;
    assign pend       = raw & intenable;
    assign fiq_status = pend & intselect;
    assign irq_status = pend & ~intselect;

    assign sp_m1    = sp - CPW'(1);
    assign cur_prio = (sp == '0) ? CPW'(NLEV) : {1'b0, stk[sp_m1[PRIO_BITS-1:0]]};

    // Highest-priority eligible IRQ; strict compare keeps the lowest index on ties.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_prio  = '1;
        best      = CPW'(NLEV);
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (irq_status[i] && !prio_mask[vect_prio[i]] &&
                ({1'b0, vect_prio[i]} < cur_prio) && ({1'b0, vect_prio[i]} < best)) begin
                best      = {1'b0, vect_prio[i]};
                win_idx   = IW'(i);
                win_prio  = vect_prio[i];
                win_valid = 1'b1;
            end
        end
    end

    assign ack_clr  = (ack && win_valid) ? ((NUM_SRC'(1) << win_idx) & edgesel) : '0;
    assign edge_clr = ((wr && is_ctrl && word == A_EDGECL) ? wdat : '0) | ack_clr;

    // Combinational read mux, only driven during a read access phase.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (is_ctrl) begin
                case (word)
                    A_IRQSTAT: rdata = 32'(irq_status);
                    A_FIQSTAT: rdata = 32'(fiq_status);
                    A_RAW:     rdata = 32'(raw);
                    A_INTSEL:  rdata = 32'(intselect);
                    A_INTEN:   rdata = 32'(intenable);
                    A_SOFT:    rdata = 32'(softint);
                    A_EDGESEL: rdata = 32'(edgesel);
                    A_PMASK:   rdata = 32'(prio_mask);
                    A_VECT:    rdata = win_valid ? vect_addr[win_idx] : def_vect;
                    A_DEFV:    rdata = def_vect;
                    A_CURPRIO: rdata = 32'(cur_prio);
                    default:   rdata = '0;
                endcase
            end else if (is_vect && in_range) begin
                rdata = vect_addr[idx];
            end else if (is_prio && in_range) begin
                rdata = 32'(vect_prio[idx]);
            end
        end
    end

    assign apb.prdata = rdata;
    assign apb.pready = 1'b1;

    // Software-visible configuration registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            intselect <= '0;
            intenable <= '0;
            softint   <= '0;
            edgesel   <= '0;
            prio_mask <= '0;
            def_vect  <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                vect_addr[i] <= '0;
                vect_prio[i] <= '1;
            end
        end else if (wr) begin
            if (is_ctrl) begin
                case (word)
                    A_INTSEL:  intselect <= wdat;
                    A_INTEN:   intenable <= intenable | wdat;
                    A_INTENCL: intenable <= intenable & ~wdat;
                    A_SOFT:    softint   <= softint | wdat;
                    A_SOFTCL:  softint   <= softint & ~wdat;
                    A_EDGESEL: edgesel   <= wdat;
                    A_PMASK:   prio_mask <= apb.pwdata[NLEV-1:0];
                    A_DEFV:    def_vect  <= apb.pwdata;
                    default:   ;
                endcase
            end else if (is_vect && in_range) begin
                vect_addr[idx] <= apb.pwdata;
            end else if (is_prio && in_range) begin
                vect_prio[idx] <= apb.pwdata[PRIO_BITS-1:0];
            end
        end
    end

    // Input sampling and rising-edge latches; a new edge beats a same-cycle clear.
    always_ff @(posedge pclk) begin
        if (rst) begin
            src_q    <= '0;
            edge_lat <= '0;
        end else begin
            src_q    <= vic_intsource;
            edge_lat <= (edge_lat & ~edge_clr) | (vic_intsource & ~src_q & edgesel);
        end
    end

    // Priority stack: push on acknowledge, pop on end-of-interrupt.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < int'(NLEV); i++) begin
                stk[i] <= '0;
            end
        end else if (ack && win_valid && (sp < CPW'(NLEV))) begin
            stk[sp[PRIO_BITS-1:0]] <= win_prio;
            sp                     <= sp + CPW'(1);
        end else if (eoi && (sp != '0)) begin
            sp <= sp_m1;
        end
    end

    // Registered active-low request lines to the CPU.
    always_ff @(posedge pclk) begin
        if (rst) begin
            nvicfiq <= 1'b1;
            nvicirq <= 1'b1;
        end else begin
            nvicfiq <= ~|fiq_status;
            nvicirq <= ~win_valid;
        end
    end
endmodule

// File: tb/tb_vic_apb_nested.sv
// Scoreboard bench for vic_apb_nested: nesting, edge latches, FIQ, masking, reset.
module tb_vic_apb_nested;
    localparam int unsigned NUM_SRC   = 32;
    localparam int unsigned PRIO_BITS = 4;
    localparam int unsigned AW        = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src;
    logic               nvicfiq;
    logic               nvicirq;

    vic_apb_nested_if #(.AW(AW)) bus ();

    vic_apb_nested #(.NUM_SRC(NUM_SRC), .PRIO_BITS(PRIO_BITS), .AW(AW)) dut (
        .pclk          (clk),
        .rst           (rst),
        .apb           (bus),
        .vic_intsource (src),
        .nvicfiq       (nvicfiq),
        .nvicirq       (nvicirq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = addr[AW-1:0];
        bus.pwdata  = data;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_t        e;
        logic [31:0] got;
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = addr[AW-1:0];
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        got = bus.prdata;
        e   = sb_q.pop_front();
        check(e.tag, got, e.val);
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic expect_pins(input string tag, input logic irq_exp, input logic fiq_exp);
        exp_t e;
        sb_q.push_back('{{tag, "_irq"}, 32'(irq_exp)});
        sb_q.push_back('{{tag, "_fiq"}, 32'(fiq_exp)});
        e = sb_q.pop_front();
        check(e.tag, 32'(nvicirq), e.val);
        e = sb_q.pop_front();
        check(e.tag, 32'(nvicfiq), e.val);
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;
        src = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        expect_pins("rst", 1'b1, 1'b1);
        check("pready", 32'(bus.pready), 32'h1);
        expect_rd("rst_irqstat", 32'h000, 32'h0);
        expect_rd("rst_fiqstat", 32'h004, 32'h0);
        expect_rd("rst_raw",     32'h008, 32'h0);
        expect_rd("rst_intsel",  32'h00C, 32'h0);
        expect_rd("rst_inten",   32'h010, 32'h0);
        expect_rd("rst_soft",    32'h018, 32'h0);
        expect_rd("rst_edgesel", 32'h020, 32'h0);
        expect_rd("rst_pmask",   32'h028, 32'h0);
        expect_rd("rst_defv",    32'h034, 32'h0);
        expect_rd("rst_unimpl",  32'h02C, 32'h0);
        expect_rd("rst_vect0",   32'h100, 32'h0);
        expect_rd("rst_prio0",   32'h200, 32'hF);
        expect_rd("rst_prio31",  32'h27C, 32'hF);
        expect_rd("rst_curprio", 32'h038, 32'h10);
        expect_rd("rst_vectrd",  32'h030, 32'h0);
        expect_rd("rst_curprio2", 32'h038, 32'h10);

        // Level IRQ with exact two-edge latency
        apb_wr(32'h10C, 32'h1000_0300);
        apb_wr(32'h20C, 32'd5);
        apb_wr(32'h010, 32'h8);
        src[3] = 1'b1;
        idle(1);
        expect_pins("lat1", 1'b1, 1'b1);
        idle(1);
        expect_pins("lat2", 1'b0, 1'b1);
        expect_rd("ack3", 32'h030, 32'h1000_0300);
        expect_rd("cur5", 32'h038, 32'd5);
        expect_pins("ack3_irq", 1'b1, 1'b1);
        apb_wr(32'h030, 32'h0);
        expect_rd("eoi_cur", 32'h038, 32'h10);
        expect_pins("eoi_irq", 1'b0, 1'b1);
        expect_rd("ack3b", 32'h030, 32'h1000_0300);

        // Nesting: higher priority preempts, lower priority is held off
        apb_wr(32'h11C, 32'h1000_0700);
        apb_wr(32'h21C, 32'd2);
        apb_wr(32'h104, 32'h1000_0100);
        apb_wr(32'h204, 32'd6);
        apb_wr(32'h010, 32'h82);
        src[7] = 1'b1;
        idle(2);
        expect_pins("nest7", 1'b0, 1'b1);
        expect_rd("ack7", 32'h030, 32'h1000_0700);
        expect_rd("cur2", 32'h038, 32'd2);
        src[1] = 1'b1;
        idle(3);
        expect_pins("src1_held", 1'b1, 1'b1);
        apb_wr(32'h030, 32'h0);
        expect_rd("pop_cur5", 32'h038, 32'd5);
        apb_wr(32'h030, 32'h0);
        expect_rd("pop_cur16", 32'h038, 32'h10);
        src[1] = 1'b0; src[3] = 1'b0; src[7] = 1'b0;
        idle(3);
        expect_pins("quiet", 1'b1, 1'b1);

        // Equal priority: lower index wins
        apb_wr(32'h110, 32'h1000_0400);
        apb_wr(32'h124, 32'h1000_0900);
        apb_wr(32'h210, 32'd3);
        apb_wr(32'h224, 32'd3);
        apb_wr(32'h010, 32'h210);
        src[4] = 1'b1; src[9] = 1'b1;
        idle(2);
        expect_rd("tie_vect", 32'h030, 32'h1000_0400);
        expect_rd("tie_cur", 32'h038, 32'd3);
        apb_wr(32'h030, 32'h0);
        src[4] = 1'b0; src[9] = 1'b0;
        idle(2);
        expect_rd("tie_pop", 32'h038, 32'h10);

        // Edge mode: one-cycle pulse is latched, acknowledge clears it
        apb_wr(32'h020, 32'h4);
        apb_wr(32'h108, 32'h1000_0200);
        apb_wr(32'h208, 32'd1);
        apb_wr(32'h010, 32'h4);
        src[2] = 1'b1;
        idle(1);
        src[2] = 1'b0;
        idle(2);
        expect_rd("edge_raw", 32'h008, 32'h4);
        expect_pins("edge_irq", 1'b0, 1'b1);
        expect_rd("edge_ack", 32'h030, 32'h1000_0200);
        expect_rd("edge_raw_clr", 32'h008, 32'h0);
        apb_wr(32'h030, 32'h0);
        expect_rd("edge_pop", 32'h038, 32'h10);

        // EDGECLEAR in the same cycle as a new rising edge: latch survives
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h024; bus.pwdata = 32'h4;
        @(negedge clk);
        bus.penable = 1'b1;
        src[2] = 1'b1;
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        expect_rd("edgeclr_race", 32'h008, 32'h4);
        apb_wr(32'h024, 32'h4);
        expect_rd("edgeclr_plain", 32'h008, 32'h0);
        src[2] = 1'b0;
        idle(2);

        // FIQ routing via soft interrupt
        apb_wr(32'h00C, 32'h1);
        apb_wr(32'h010, 32'h1);
        apb_wr(32'h018, 32'h1);
        idle(1);
        expect_pins("fiq_on", 1'b1, 1'b0);
        expect_rd("fiq_stat", 32'h004, 32'h1);
        expect_rd("fiq_irqstat", 32'h000, 32'h0);
        expect_rd("soft_rd", 32'h018, 32'h1);
        apb_wr(32'h01C, 32'h1);
        idle(1);
        expect_pins("fiq_off", 1'b1, 1'b1);

        // Priority mask hides src3 and VECTADDR falls back to the default
        apb_wr(32'h034, 32'hDEF0_0000);
        apb_wr(32'h028, 32'h20);
        src[3] = 1'b1;
        idle(2);
        expect_pins("mask", 1'b1, 1'b1);
        expect_rd("mask_irqstat", 32'h000, 32'h8);
        expect_rd("mask_defv", 32'h030, 32'hDEF0_0000);
        expect_rd("mask_nopush", 32'h038, 32'h10);
        apb_wr(32'h028, 32'h0);
        idle(1);
        expect_pins("unmask", 1'b0, 1'b1);

        // Reset while two levels are stacked and IRQ is asserted
        expect_rd("mid_ack3", 32'h030, 32'h1000_0300);
        src[7] = 1'b1;
        idle(2);
        expect_rd("mid_ack7", 32'h030, 32'h1000_0700);
        expect_rd("mid_cur2", 32'h038, 32'd2);
        apb_wr(32'h018, 32'h4);
        idle(1);
        expect_pins("mid_irq", 1'b0, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        expect_pins("mid_rst", 1'b1, 1'b1);
        expect_rd("mid_cur", 32'h038, 32'h10);
        expect_rd("mid_inten", 32'h010, 32'h0);
        idle(2);
        expect_pins("mid_after", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
